// File: rtl/ctrlport_to_spi_master.sv
// ctrlport_to_spi_master: tunnels ControlPort requests as 64-bit SPI mode-0 frames and returns the response
module ctrlport_to_spi_master #(
   parameter int SCLK_DIVIDER = 5,
   parameter int CS_GAP       = 4
) (
   input  logic        ctrlport_clk,
   input  logic        ctrlport_rst_n,
   input  logic        s_ctrlport_req_wr,
   input  logic        s_ctrlport_req_rd,
   input  logic [19:0] s_ctrlport_req_addr,
   input  logic [31:0] s_ctrlport_req_data,
   output logic        s_ctrlport_resp_ack,
   output logic [1:0]  s_ctrlport_resp_status,
   output logic [31:0] s_ctrlport_resp_data,
   output logic        sclk,
   output logic        cs_n,
   output logic        mosi,
   input  logic        miso,
   output logic        busy
);
   localparam logic [2:0] IDLE = 3'd0, SETUP = 3'd1, SHIFT = 3'd2, HOLD = 3'd3, RESP = 3'd4, GAP = 3'd5;
   logic [2:0]  state;
   logic [15:0] cnt;
   logic [6:0]  bits;
   logic [63:0] tx;
   logic [39:0] rx;
   logic        rd_q;
   logic        req, bad, last_div, last_gap;
   logic [63:0] frame;
   always_comb begin
      req      = s_ctrlport_req_wr | s_ctrlport_req_rd;
      bad      = (s_ctrlport_req_wr & s_ctrlport_req_rd) | (s_ctrlport_req_addr[19:15] != 5'd0);
      frame    = s_ctrlport_req_wr ? {1'b1, s_ctrlport_req_addr[14:0], s_ctrlport_req_data, 16'h0}
                                   : {1'b0, s_ctrlport_req_addr[14:0], 48'h0};
      last_div = cnt == 16'(SCLK_DIVIDER - 1);
      last_gap = cnt == 16'(CS_GAP - 1);
   end
   always_ff @(posedge ctrlport_clk) begin
      if (!ctrlport_rst_n) begin
         state                  <= IDLE;
         cnt                    <= '0;
         bits                   <= '0;
         tx                     <= '0;
         rx                     <= '0;
         rd_q                   <= 1'b0;
         cs_n                   <= 1'b1;
         sclk                   <= 1'b0;
         mosi                   <= 1'b0;
         busy                   <= 1'b0;
         s_ctrlport_resp_ack    <= 1'b0;
         s_ctrlport_resp_status <= 2'b00;
         s_ctrlport_resp_data   <= '0;
      end else begin
         s_ctrlport_resp_ack <= 1'b0;
         case (state)
            IDLE: if (req) begin
               if (bad) begin
                  s_ctrlport_resp_ack    <= 1'b1;
                  s_ctrlport_resp_status <= 2'b01;
                  s_ctrlport_resp_data   <= '0;
               end else begin
                  state <= SETUP;
                  cs_n  <= 1'b0;
                  mosi  <= frame[63];
                  tx    <= frame;
                  rd_q  <= ~s_ctrlport_req_wr;
                  busy  <= 1'b1;
                  cnt   <= '0;
                  bits  <= '0;
               end
            end
            SETUP: begin
               cnt <= last_div ? 16'd0 : cnt + 16'd1;
               if (last_div) begin
                  sclk  <= 1'b1;
                  rx    <= {rx[38:0], miso};
                  bits  <= 7'd1;
                  state <= SHIFT;
               end
            end
            // each half-period ends either with a fall (shift MOSI) or a rise (sample MISO)
            SHIFT: begin
               cnt <= last_div ? 16'd0 : cnt + 16'd1;
               if (last_div) begin
                  if (sclk) begin
                     sclk <= 1'b0;
                     mosi <= tx[62];
                     tx   <= {tx[62:0], 1'b0};
                  end else if (bits == 7'd64) begin
                     state <= HOLD;
                  end else begin
                     sclk <= 1'b1;
                     rx   <= {rx[38:0], miso};
                     bits <= bits + 7'd1;
                  end
               end
            end
            HOLD: begin
               cnt <= last_div ? 16'd0 : cnt + 16'd1;
               if (last_div) begin
                  cs_n  <= 1'b1;
                  state <= RESP;
               end
            end
            RESP: begin
               s_ctrlport_resp_ack    <= 1'b1;
               s_ctrlport_resp_status <= rx[2] ? rx[1:0] : 2'b01;
               s_ctrlport_resp_data   <= (rx[2] && rd_q) ? rx[39:8] : 32'h0;
               cnt                    <= '0;
               state                  <= GAP;
            end
            GAP: begin
               cnt <= last_gap ? 16'd0 : cnt + 16'd1;
               if (last_gap) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ctrlport_to_spi_master.sv
// tb_ctrlport_to_spi_master: directed and random ControlPort-over-SPI transactions against a frame-level slave model
module tb_ctrlport_to_spi_master;
   localparam int D = 2;
   localparam int G = 4;
   logic        clk = 1'b0, rst_n = 1'b0, wr = 1'b0, rd = 1'b0, miso = 1'b0;
   logic [19:0] addr = '0;
   logic [31:0] wdata = '0;
   logic        ack, sclk, cs_n, mosi, busy;
   logic [1:0]  status;
   logic [31:0] rdata;
   int vectors = 0, miscompares = 0, cyc = 0, acks = 0, frames = 0, mbits = 0;
   logic [63:0] mcap = '0, sframe = '0;
   logic        in_frame = 1'b0;

   ctrlport_to_spi_master #(.SCLK_DIVIDER(D), .CS_GAP(G)) dut (
      .ctrlport_clk(clk), .ctrlport_rst_n(rst_n),
      .s_ctrlport_req_wr(wr), .s_ctrlport_req_rd(rd),
      .s_ctrlport_req_addr(addr), .s_ctrlport_req_data(wdata),
      .s_ctrlport_resp_ack(ack), .s_ctrlport_resp_status(status), .s_ctrlport_resp_data(rdata),
      .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso), .busy(busy));

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;
   always @(negedge clk) if (ack === 1'b1) acks++;

   // SPI slave: captures MOSI on rises, drives the next MISO bit on falls
   always @(cs_n or sclk) begin
      if (cs_n !== 1'b0) in_frame = 1'b0;
      else if (!in_frame) begin
         in_frame = 1'b1; mbits = 0; mcap = '0; frames++; miso = sframe[63];
      end else if (sclk === 1'b1) begin
         mcap = {mcap[62:0], mosi}; mbits++;
      end else miso = (mbits < 64) ? sframe[63 - mbits] : 1'b0;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic run(input string tag, input logic w, input logic r, input logic [19:0] a,
                      input logic [31:0] d, input logic [7:0] resp, input logic [31:0] rdat, input int inject);
      logic legal, got;
      logic [63:0] exp_mosi;
      logic [1:0]  exp_st, st;
      logic [31:0] exp_dt, dt;
      int c0, lat, exp_lat, f0, a0;
      legal    = (w ^ r) && (a[19:15] == 5'd0);
      sframe   = (r && !w) ? {24'h0, rdat, resp} : {56'h0, resp};
      exp_mosi = w ? {1'b1, a[14:0], d, 16'h0} : {1'b0, a[14:0], 48'h0};
      exp_st   = !legal ? 2'b01 : resp[2] ? resp[1:0] : 2'b01;
      exp_dt   = (legal && resp[2] && r && !w) ? rdat : 32'h0;
      exp_lat  = legal ? 130 * D + 2 : 1;
      f0 = frames; a0 = acks; got = 1'b0; lat = 0; st = 'x; dt = 'x;
      @(negedge clk); wr = w; rd = r; addr = a; wdata = d; c0 = cyc;
      @(negedge clk); wr = 1'b0; rd = 1'b0;
      for (int i = 1; i < 200 * D && !got; i++) begin
         if (ack === 1'b1) begin
            got = 1'b1; lat = cyc - c0; st = status; dt = rdata;
         end else begin
            if (inject != 0 && i == inject) check({tag, " busy"}, 64'(busy), 64'd1);
            rd = (inject != 0 && i == inject);
            addr = (inject != 0 && i == inject) ? 20'h00555 : a;
            @(negedge clk);
         end
      end
      rd = 1'b0;
      check({tag, " ack"}, 64'(got), 64'd1);
      check({tag, " latency"}, 64'(lat), 64'(exp_lat));
      check({tag, " status"}, 64'(st), 64'(exp_st));
      check({tag, " data"}, 64'(dt), 64'(exp_dt));
      repeat (G + 2) @(negedge clk);
      check({tag, " ack count"}, 64'(acks - a0), 64'd1);
      check({tag, " frames"}, 64'(frames - f0), legal ? 64'd1 : 64'd0);
      if (legal) begin
         check({tag, " bits"}, 64'(mbits), 64'd64);
         check({tag, " mosi"}, mcap, exp_mosi);
      end
   endtask

   initial begin
      logic [19:0] ra;
      logic        rw;
      int a0;
      repeat (3) @(negedge clk);
      check("rst cs_n", 64'(cs_n), 64'd1);
      check("rst sclk", 64'(sclk), 64'd0);
      check("rst mosi", 64'(mosi), 64'd0);
      check("rst ack", 64'(ack), 64'd0);
      check("rst status", 64'(status), 64'd0);
      check("rst data", 64'(rdata), 64'd0);
      check("rst busy", 64'(busy), 64'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      run("write", 1'b1, 1'b0, 20'h00123, 32'hDEADBEEF, 8'h04, 32'h0, 0);
      run("read", 1'b0, 1'b1, 20'h07FFF, 32'h0, 8'h04, 32'hCAFEF00D, 0);
      run("nack", 1'b0, 1'b1, 20'h07FFF, 32'h0, 8'h00, 32'h12345678, 0);
      run("tserr", 1'b1, 1'b0, 20'h00042, 32'h01020304, 8'h06, 32'h0, 0);
      run("badaddr", 1'b1, 1'b0, 20'h80000, 32'h11111111, 8'h04, 32'h0, 0);
      run("bothstb", 1'b1, 1'b1, 20'h00010, 32'h22222222, 8'h04, 32'h0, 0);
      run("busydrop", 1'b0, 1'b1, 20'h01234, 32'h0, 8'h04, 32'hA5A5F00F, 100);
      // reset in the middle of a write frame
      sframe = 64'h4;
      @(negedge clk); wr = 1'b1; addr = 20'h00321; wdata = 32'h55AA55AA;
      @(negedge clk); wr = 1'b0;
      for (int i = 0; i < 500 && mbits < 20; i++) @(negedge clk);
      check("abort reached bit 20", 64'(mbits >= 20), 64'd1);
      a0 = acks; rst_n = 1'b0;
      @(negedge clk);
      check("abort cs_n", 64'(cs_n), 64'd1);
      check("abort sclk", 64'(sclk), 64'd0);
      check("abort busy", 64'(busy), 64'd0);
      rst_n = 1'b1;
      repeat (300) @(negedge clk);
      check("abort no ack", 64'(acks - a0), 64'd0);
      run("post-abort", 1'b1, 1'b0, 20'h00321, 32'h55AA55AA, 8'h04, 32'h0, 0);
      for (int k = 0; k < 10; k++) begin
         rw = 1'($urandom_range(0, 1));
         ra = {5'h0, 15'($urandom)};
         if (k == 7) ra[19:15] = 5'($urandom_range(1, 31));
         run("random", rw, ~rw, ra, $urandom, 8'($urandom), $urandom, 0);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
